// File: rtl/pc_sequencer_if.sv
// Bundles the sequencer's fetch handshake, redirect inputs and status outputs.
// master is the sequencer side; slave is the pipeline and fetch side.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    logic              fetch_req;
    logic              fetch_ack;
    logic              stall;
    logic              br_taken;
    logic              jmp;
    logic              ret;
    logic              irq;
    logic              irq_ack;
    logic              in_isr;
    logic              halt;
    logic              halted;

    modport master (
        output pc_q, epc, fetch_req, irq_ack, in_isr, halted,
        input  fetch_ack, stall, br_taken, br_target, jmp, jmp_target,
               ret, irq, halt
    );

    modport slave (
        input  pc_q, epc, fetch_req, irq_ack, in_isr, halted,
        output fetch_ack, stall, br_taken, br_target, jmp, jmp_target,
               ret, irq, halt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential fetch, branch/jump redirects,
// interrupt entry/return and halt-until-interrupt.
//
// state | meaning
// BOOT  | first cycle out of reset, pc at RESET_VEC, no fetch
// FETCH | fetch of pc_q requested; redirects and acks are applied here
// IRQ   | one-cycle interrupt acknowledge, then vector to IRQ_VEC
// HALT  | pc frozen; only an unmasked irq (or reset) leaves
module pc_sequencer #(
    parameter int                   ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]    RESET_VEC = 16'h0000,
    parameter logic [ADDR_W-1:0]    IRQ_VEC   = 16'h0010,
    parameter int unsigned          INC       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        IRQ   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] epc;
    logic              in_isr;
    logic              fetch_req;
    logic              irq_ack;
    logic              halted;

    // Status flags are registered alongside every state transition so they
    // always equal the decode of the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc        <= RESET_VEC;
            epc       <= '0;
            in_isr    <= 1'b0;
            fetch_req <= 1'b0;
            irq_ack   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                end
                FETCH: begin
                    if (!bus.stall) begin
                        if (bus.halt) begin
                            state     <= HALT;
                            fetch_req <= 1'b0;
                            halted    <= 1'b1;
                        end else if (bus.ret && in_isr) begin
                            pc     <= epc;
                            in_isr <= 1'b0;
                        end else if (bus.br_taken) begin
                            pc <= bus.br_target;
                        end else if (bus.jmp) begin
                            pc <= bus.jmp_target;
                        end else if (bus.fetch_ack && bus.irq && !in_isr) begin
                            epc       <= pc + STEP;
                            state     <= IRQ;
                            fetch_req <= 1'b0;
                            irq_ack   <= 1'b1;
                        end else if (bus.fetch_ack) begin
                            pc <= pc + STEP;
                        end
                    end
                end
                IRQ: begin
                    pc        <= IRQ_VEC;
                    in_isr    <= 1'b1;
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                    irq_ack   <= 1'b0;
                end
                HALT: begin
                    // Wake resumes at the halted PC itself, not pc+INC.
                    if (bus.irq && !in_isr) begin
                        epc     <= pc;
                        state   <= IRQ;
                        halted  <= 1'b0;
                        irq_ack <= 1'b1;
                    end
                end
                default: begin
                    state     <= BOOT;
                    fetch_req <= 1'b0;
                    irq_ack   <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_q      = pc;
    assign bus.epc       = epc;
    assign bus.in_isr    = in_isr;
    assign bus.fetch_req = fetch_req;
    assign bus.irq_ack   = irq_ack;
    assign bus.halted    = halted;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: a table of per-cycle stimulus with
// hand-computed post-edge expectations, plus async reset corner cases.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_sequencer_if #(.ADDR_W(16)) bus ();

    pc_sequencer #(
        .ADDR_W   (16),
        .RESET_VEC(16'h0000),
        .IRQ_VEC  (16'h0010),
        .INC      (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack, stall, halt, ret, br;
        logic [15:0] bt;
        logic        jmp;
        logic [15:0] jt;
        logic        irq;
        logic [15:0] pc, epc;
        logic        isr, fr, ia, hl;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(
        input logic ack, stall, halt, ret, br, input logic [15:0] bt,
        input logic jmp, input logic [15:0] jt, input logic irq,
        input logic [15:0] pc, epc, input logic isr, fr, ia, hl);
        vec_t v;
        v.ack = ack; v.stall = stall; v.halt = halt; v.ret = ret; v.br = br;
        v.bt = bt; v.jmp = jmp; v.jt = jt; v.irq = irq;
        v.pc = pc; v.epc = epc; v.isr = isr; v.fr = fr; v.ia = ia; v.hl = hl;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx,
                             input logic [15:0] pc, epc,
                             input logic isr, fr, ia, hl);
        vectors++;
        chk({tag, ".pc_q"},      idx, bus.pc_q, pc);
        chk({tag, ".epc"},       idx, bus.epc, epc);
        chk({tag, ".in_isr"},    idx, 16'(bus.in_isr), 16'(isr));
        chk({tag, ".fetch_req"}, idx, 16'(bus.fetch_req), 16'(fr));
        chk({tag, ".irq_ack"},   idx, 16'(bus.irq_ack), 16'(ia));
        chk({tag, ".halted"},    idx, 16'(bus.halted), 16'(hl));
    endtask

    task automatic drive(input logic ack, stall, halt, ret, br,
                         input logic [15:0] bt, input logic jmp,
                         input logic [15:0] jt, input logic irq);
        bus.fetch_ack = ack; bus.stall = stall; bus.halt = halt;
        bus.ret = ret; bus.br_taken = br; bus.br_target = bt;
        bus.jmp = jmp; bus.jmp_target = jt; bus.irq = irq;
    endtask

    initial begin
        //             ack st hl rt br bt       jmp jt       irq  pc       epc      isr fr ia hl
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0)); // boot
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 16'h0000, 0, 1, 0, 0)); // backpressure
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0005, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0005, 16'h0000, 0, 1, 0, 0)); // stall
        tbl.push_back(mk(1, 1, 0, 0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0005, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0040, 1, 16'h0080, 0, 16'h0040, 16'h0000, 0, 1, 0, 0)); // br over jmp
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0080, 16'h0000, 0, 1, 0, 0)); // jmp w/o ack
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h0006, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0007, 16'h0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0007, 16'h0008, 0, 0, 1, 0)); // irq accept
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0008, 1, 1, 0, 0)); // IRQ ignores stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0011, 16'h0008, 1, 1, 0, 0)); // masked
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h0008, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 16'h0008, 0, 1, 0, 0)); // ret
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0009, 16'h0008, 0, 1, 0, 0)); // stray ret
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0020, 16'h0008, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 16'h0008, 0, 0, 0, 1)); // halt
        tbl.push_back(mk(1, 0, 1, 0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0020, 16'h0008, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0020, 16'h0008, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 16'h0008, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 16'h0050, 0, 16'h0000, 0, 16'h0020, 16'h0008, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 16'h0008, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 16'h0020, 0, 0, 1, 0)); // wake
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0020, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 16'h0020, 0, 1, 0, 0)); // resume
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 16'h0020, 0, 1, 0, 0)); // halt under stall
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'hFFFF, 16'h0020, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0020, 0, 1, 0, 0)); // pc wrap
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'hFFFF, 16'h0020, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 0, 0, 1, 0)); // epc wrap
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0000, 1, 0, 0, 1)); // halt over ret
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0000, 1, 0, 0, 1)); // masked wake
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0000, 1, 0, 0, 1));

        drive(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
        #2 rst = 1'b0;
        #1 check_all("reset_async", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 check_all("reset_hold", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ack, tbl[i].stall, tbl[i].halt, tbl[i].ret, tbl[i].br,
                  tbl[i].bt, tbl[i].jmp, tbl[i].jt, tbl[i].irq);
            @(posedge clk);
            #1 check_all("vec", i, tbl[i].pc, tbl[i].epc, tbl[i].isr,
                         tbl[i].fr, tbl[i].ia, tbl[i].hl);
        end

        // Reset while halted inside a handler: epc and in_isr must clear.
        drive(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
        #2 rst = 1'b0;
        #1 check_all("reset_in_halt", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset asserted mid-cycle while in IRQ.
        drive(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1);
        @(posedge clk);
        #1 check_all("boot_irq", 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
        @(posedge clk);
        #1 check_all("irq_enter", 0, 16'h0000, 16'h0001, 0, 0, 1, 0);
        #2 rst = 1'b0;
        #1 check_all("reset_in_irq", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        @(posedge clk);
        #1 check_all("reset_in_irq_hold", 1, 16'h0000, 16'h0000, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller for the 16-bit program counter register: computes and loads the next PC every cycle from sequential increment, branch/jump redirects, interrupt entry and return. It handshakes with instruction memory and supports a halt/wait-for-interrupt state. It sits between the decode/execute stages, which drive the redirects and stall, and the fetch stage, which consumes `pc_q`.

## Interface
Parameters:
- `ADDR_W`, 16: PC width.
- `RESET_VEC`, 16'h0000: PC value after reset.
- `IRQ_VEC`, 16'h0010: interrupt handler entry address.
- `INC`, 1: sequential increment (word-addressed memory).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_q` out ADDR_W: current PC, registered.
- `fetch_req` out 1: fetch of `pc_q` requested.
- `fetch_ack` in 1: instruction memory accepted the fetch this cycle.
- `stall` in 1: pipeline stall; freezes the sequencer.
- `br_taken` in 1, `br_target` in ADDR_W: taken branch and its target.
- `jmp` in 1, `jmp_target` in ADDR_W: unconditional jump and its target.
- `ret` in 1: return from interrupt.
- `irq` in 1: level-sensitive interrupt request.
- `irq_ack` out 1: high for exactly the one cycle spent in IRQ state.
- `epc` out ADDR_W: saved return PC, registered.
- `in_isr` out 1: handler active; nested interrupts are masked.
- `halt` in 1: enter halt.
- `halted` out 1: sequencer is in HALT.

## Operation
- FSM states: BOOT, FETCH, IRQ, HALT.
- Outputs are Moore-decoded from registers; no combinational input-to-output path.
  - `fetch_req` = (state==FETCH).
  - `irq_ack` = (state==IRQ).
  - `halted` = (state==HALT).
- BOOT: `pc_q`=RESET_VEC, no fetch; always goes to FETCH next cycle.
- FETCH with `stall`=1: all state, `pc_q`, `epc` and `in_isr` hold. `fetch_ack` and all redirects are ignored; the requester must hold them.
- FETCH with `stall`=0: the first true condition in this priority list wins.
  1. `halt`: go to HALT; `pc_q` holds.
  2. `ret` && `in_isr`: `pc_q` <= `epc`; `in_isr` <= 0. A `ret` with `in_isr`=0 is ignored.
  3. `br_taken`: `pc_q` <= `br_target`.
  4. `jmp`: `pc_q` <= `jmp_target`.
  5. `fetch_ack` && `irq` && !`in_isr`: `epc` <= `pc_q`+INC; go to IRQ.
  6. `fetch_ack`: `pc_q` <= `pc_q`+INC.
  7. Otherwise: `pc_q` holds and the fetch stays requested.
- Redirects (rules 2–4) take effect regardless of `fetch_ack`. The outstanding fetch is abandoned.
- IRQ: one cycle. On exit: `pc_q` <= IRQ_VEC, `in_isr` <= 1, go to FETCH. `stall` is ignored in this state.
- HALT: `pc_q` holds. Exits only on `irq` && !`in_isr`: `epc` <= `pc_q` (resume at the halted PC), then go to IRQ. Exit is also possible via reset. `halt`, redirects and `stall` are ignored in this state.
- Arithmetic: all additions are modulo 2^ADDR_W. `pc_q`=16'hFFFF plus 1 gives 16'h0000. Same rule for `epc`.
- `epc` is written only on interrupt entry and is otherwise stable.

## Timing
- Reset values (asserted asynchronously, immediately):
  - state=BOOT, `pc_q`=RESET_VEC, `epc`=0.
  - `in_isr`=0, `fetch_req`=0, `irq_ack`=0, `halted`=0.
- After `rst` deasserts:
  - First edge: BOOT to FETCH; `fetch_req`=1 from cycle 1.
- Sequential and redirect latency: a decision on edge N gives the new `pc_q` immediately after edge N (1 cycle).
- Interrupt latency:
  - Accept on edge N.
  - Cycle N+1: `irq_ack`=1, `fetch_req`=0.
  - After edge N+1: `pc_q`=IRQ_VEC, `in_isr`=1, `fetch_req`=1.
- Halt latency:
  - `halt` sampled on edge N gives `halted`=1 and `fetch_req`=0 after N.
  - An `irq` while halted gives `irq_ack` in the next cycle.
- `irq` held high while `in_isr`=1 has no effect. It is taken on the first qualifying `fetch_ack` after the return.
- Reset asserted mid-IRQ or mid-HALT: same reset values; `epc` is cleared.

## Test plan
- Reset/boot: hold `rst`=0, then release with `fetch_ack`=1 every cycle → `pc_q` reads 0000, 0000, 0001, 0002, 0003; `fetch_req` rises one cycle after release.
- Backpressure and stall: pulse `fetch_ack` on alternate cycles, then `stall`=1 for 3 cycles with `fetch_ack`=1 → `pc_q` advances only on acked, unstalled cycles; it is frozen during the stall.
- Redirect priority: at `pc_q`=0005 assert `br_taken`(0040), `jmp`(0080) and `fetch_ack` together → `pc_q`=0040. With `jmp` alone → 0080.
- Interrupt entry/return:
  - At `pc_q`=0007 with `irq`=1 and `fetch_ack`=1 → `irq_ack` is a 1-cycle pulse, `epc`=0008, `pc_q`=0010, `in_isr`=1.
  - `irq` kept high has no effect.
  - `ret` → `pc_q`=0008, `in_isr`=0.
- Halt/wake: `halt` at `pc_q`=0020 → `halted`=1, `fetch_req`=0, PC stable for 5 cycles. Then `irq` → `epc`=0020, `pc_q`=0010.
- Wrap and async reset:
  - With `jmp_target`=FFFF, then one ack → `pc_q`=0000.
  - Assert `rst` mid-cycle while in IRQ → all outputs go to reset values before the next edge.
